// File: rtl/mul_seq.sv
// mul_seq: sequential 16x16->32 unsigned multiplier.
// Shift-add with one 16-bit ripple addition per clock. Operands are accepted
// on an in_valid/in_ready handshake and the product is returned on an
// out_valid/out_ready handshake.
//
// Optional build macro: MUL_SEQ_EARLY_TERM_EN
//   When defined, RUN finishes as soon as the remaining multiplier bits are
//   all zero. The product is the same in both builds; only latency changes.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous reset, active high
//   in_valid  in   1   a/b valid
//   in_ready  out  1   ready for operands (IDLE only)
//   a         in  16   multiplicand, unsigned
//   b         in  16   multiplier, unsigned
//   out_valid out  1   p valid (DONE only)
//   out_ready in   1   consumer takes p
//   p         out 32   product, registered, held until the next result
//   busy      out  1   iterating (RUN)
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// RUN   | one partial-product add per clock
// DONE  | product presented, out_valid=1 until taken

module mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_a;
    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic [3:0]  r_cnt;
    logic [31:0] r_p;

    logic [15:0] w_y;
    logic [15:0] w_sum;
    logic        w_co;
    logic        w_carry;
    logic        w_accept;
    logic        w_step;
    logic        w_last;
    logic        w_early;

`ifdef MUL_SEQ_EARLY_TERM_EN
    logic [15:0] r_brem;
    logic [4:0]  w_shamt;
    logic [31:0] w_early_p;

    // Once every remaining multiplier bit is zero, the rest of the steps would
    // only shift. Do that shift in one go: after cnt steps the product sits
    // in {hi,lo} scaled up by 2^(16-cnt).
    assign w_early   = (r_state == S_RUN) && (r_brem == 16'h0000);
    assign w_shamt   = 5'd16 - {1'b0, r_cnt};
    assign w_early_p = {r_hi, r_lo} >> w_shamt;
`else
    assign w_early   = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_step   = (r_state == S_RUN) && !w_early;
    assign w_last   = (r_cnt == 4'hF);

    // Shared 16-bit ripple adder: hi + (lo[0] ? a : 0)
    assign w_y = r_lo[0] ? r_a : 16'h0000;

    always_comb begin
        w_carry = 1'b0;
        w_sum   = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            w_sum[k] = r_hi[k] ^ w_y[k] ^ w_carry;
            w_carry  = (r_hi[k] & w_y[k]) | (w_carry & (r_hi[k] ^ w_y[k]));
        end
        w_co = w_carry;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)          w_next = S_RUN;
            S_RUN:  if (w_early || w_last) w_next = S_DONE;
            S_DONE: if (out_ready)         w_next = S_IDLE;
            default:                       w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_RUN);
    end

    assign p = r_p;

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= 16'h0000;
            r_hi  <= 16'h0000;
            r_lo  <= 16'h0000;
            r_cnt <= 4'h0;
            r_p   <= 32'h0000_0000;
`ifdef MUL_SEQ_EARLY_TERM_EN
            r_brem <= 16'h0000;
`endif
        end else if (w_accept) begin
            r_a   <= a;
            r_hi  <= 16'h0000;
            r_lo  <= b;
            r_cnt <= 4'h0;
`ifdef MUL_SEQ_EARLY_TERM_EN
            r_brem <= b;
`endif
        end else if (w_step) begin
            r_hi  <= {w_co, w_sum[15:1]};
            r_lo  <= {w_sum[0], r_lo[15:1]};
            r_cnt <= r_cnt + 4'd1;
`ifdef MUL_SEQ_EARLY_TERM_EN
            r_brem <= r_brem >> 1;
`endif
            // Final step: capture the post-step {hi,lo} directly
            if (w_last) begin
                r_p <= {w_co, w_sum, r_lo[15:1]};
            end
`ifdef MUL_SEQ_EARLY_TERM_EN
        end else if (w_early) begin
            r_p <= w_early_p;
`endif
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] p;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: an operation is a product plus a latency in cycles.
    // mode 0 = waiting for operands, 1 = computing, 2 = result offered.
    int          m_mode = 0;
    int          m_left = 0;
    logic [31:0] m_pend = 32'h0;
    logic [31:0] m_p    = 32'h0;

    function automatic int exp_lat(input logic [15:0] bv);
`ifdef MUL_SEQ_EARLY_TERM_EN
        int m;
        if (bv == 16'h0000) return 1;
        m = 0;
        for (int i = 0; i < 16; i++) if (bv[i]) m = i;
        return (m + 2 < 16) ? m + 2 : 16;
`else
        return 16;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_left = 0;
            m_p    = 32'h0;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    m_pend = 32'(a) * 32'(b);
                    m_left = exp_lat(b);
                    m_mode = 1;
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_p    = m_pend;
                        m_mode = 2;
                    end
                end
                default: if (out_ready) m_mode = 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("model in_ready",  32'(in_ready),  32'(m_mode == 0));
        chk("model out_valid", 32'(out_valid), 32'(m_mode == 2));
        chk("model busy",      32'(busy),      32'(m_mode == 1));
        chk("model p",         p,              m_p);
    end

    // One operation with literal expectations. hold = cycles out_ready stays
    // low after out_valid; disturb = wiggle in_valid/a/b while running.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] exp_p, input int lat_def, input int lat_et,
                          input int hold, input bit disturb, input string name);
        int n;
        int lat;
`ifdef MUL_SEQ_EARLY_TERM_EN
        lat = lat_et;
`else
        lat = lat_def;
`endif
        out_ready = (hold == 0);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            if (disturb && n == 0) begin
                in_valid = 1'b1;
                a = ~av;
                b = ~bv;
            end
            if (disturb && n == 1) begin
                in_valid = 1'b0;
                a = 16'h5A5A;
                b = 16'hA5A5;
            end
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            chk({name, " timeout"}, 32'(n), 32'(lat));
        end else begin
            chk({name, " latency"}, 32'(n), 32'(lat));
            chk({name, " p"}, p, exp_p);
            if (hold > 0) begin
                repeat (hold) @(posedge clk);
                #1;
                chk({name, " held p"}, p, exp_p);
                chk({name, " held in_ready"}, 32'(in_ready), 32'd0);
                chk({name, " held out_valid"}, 32'(out_valid), 32'd1);
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            chk({name, " back to idle"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #5;
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset p",         p,              32'h0);
        #7 rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'd3,    16'd5,    32'h0000_000F, 16, 4,  0, 1'b0, "3x5");
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16, 16, 0, 1'b0, "ffff_sq");
        run_op(16'h1234, 16'h0100, 32'h0012_3400, 16, 10, 10, 1'b0, "backpressure");
        run_op(16'd2,    16'd7,    32'h0000_000E, 16, 4,  0, 1'b0, "2x7");
        run_op(16'hABCD, 16'h0000, 32'h0000_0000, 16, 1,  0, 1'b0, "b_zero");
        run_op(16'hABCD, 16'h0001, 32'h0000_ABCD, 16, 2,  0, 1'b0, "b_one");
        run_op(16'h0123, 16'h0456, 32'h0004_EDC2, 16, 12, 0, 1'b1, "ignored_stim");

        // Reset in the middle of RUN
        a = 16'h00FF;
        b = 16'h00FF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready",  32'(in_ready),  32'd1);
        chk("abort busy",      32'(busy),      32'd0);
        chk("abort p",         p,              32'h0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_op(16'h8000, 16'h0002, 32'h0001_0000, 16, 3, 0, 1'b0, "after_reset");

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential 16×16→32 unsigned multiplier controller that time-shares a single instance of the team's 16-bit ripple `adder` (16-bit sum plus carry-out) over shift-add iterations. Operands are accepted through a valid/ready handshake, and one partial-product addition is performed per clock. The result is presented on a second valid/ready handshake. It sits beside the ALU as the multiply path; the area cost is one adder plus control.

## Interface
- No parameters. Operand width is fixed at 16 to match `adder`.
- `clk  in  1` – sole clock, rising edge.
- `rst  in  1` – asynchronous, active-high reset.
- `in_valid  in  1` – operands `a`/`b` valid.
- `in_ready  out  1` – block can accept operands (high only in IDLE).
- `a  in  16` – multiplicand, unsigned.
- `b  in  16` – multiplier, unsigned.
- `out_valid  out  1` – `p` valid (high only in DONE).
- `out_ready  in  1` – consumer accepts `p`.
- `p  out  32` – product `a*b`.
- `busy  out  1` – high in RUN.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - RUN: iterating.
  - DONE: `out_valid=1`.
- Transitions:
  - IDLE→RUN on an edge with `in_valid & in_ready`.
  - RUN→DONE on completion.
  - DONE→IDLE on an edge with `out_valid & out_ready`.
  - No other transitions.
- Accept edge actions:
  - `a_r<=a`, `hi<=0` (16b), `lo<=b` (16b), `brem<=b`, `cnt<=0` (4b).
  - Operands are sampled only here; later changes on `a`/`b` are ignored.
- Adder hookup:
  - `x=hi`, `y = lo[0] ? a_r : 16'h0000`.
  - Yields `sum[15:0]` and `co`.
- RUN step (each edge):
  - `hi<={co,sum[15:1]}`, `lo<={sum[0],lo[15:1]}`, `brem<=brem>>1`, `cnt<=cnt+1`.
- Completion:
  - On the step edge where `cnt==15`, load `p<={co,sum,lo[15:1]}` (the post-step `{hi,lo}`) and go to DONE.
  - `cnt` then wraps to 0, which is unused.
- `p` is a registered output.
  - It is loaded only on entry to DONE.
  - It holds its value through DONE and IDLE until the next load.
- `out_valid` is held until the handshake; `p` is stable while `out_valid=1`.
- `in_valid` seen while not IDLE is ignored; there is no queueing.
- Reset values:
  - State IDLE; `in_ready=1`, `out_valid=0`, `busy=0`.
  - `p=0`, `hi=lo=a_r=brem=0`, `cnt=0`.
- Reset asserted mid-RUN or in DONE aborts the operation; the pending result is discarded.

## Timing
- Without early termination:
  - `out_valid` rises 16 cycles after the accept edge (steps on edges E1..E16; DONE after E16).
  - `in_ready` is low from E0 until the edge after the output handshake.
- Minimum issue interval: 18 cycles with `out_ready` held high (16 RUN, 1 DONE, 1 IDLE).
- DONE→IDLE happens on the handshake edge. The new accept can occur on the following edge; no same-cycle bypass.
- Combinational critical path: `hi` → `adder` carry chain (16 stages) → `hi`/`lo`/`p` registers.

## Configuration
- Macro `MUL_SEQ_EARLY_TERM_EN`.
- Defined (early termination):
  - At the start of each RUN cycle, if `brem==0`, no step is performed that edge.
  - Instead load `p<={hi,lo} >> (16-cnt)` (zero-extended logical shift; `cnt=0` gives `hi`=0) and enter DONE.
  - Latency is `min(16, m+2)` cycles, where `m` is the index of the MSB set in `b`; `b==0` gives latency 1.
  - The `cnt==15` completion rule still applies, so `b[15]=1` takes 16.
- Undefined:
  - `brem` and the barrel shift are compiled out.
  - Latency is always 16.
- Products are identical in both builds.

## Test plan
- Basic multiply: `a=3, b=5`, `out_ready=1`.
  - `p=32'h0000000F`.
  - Latency 16 without the macro, 4 with it (m=2).
- Full-scale carry chain: `a=b=16'hFFFF`.
  - `p=32'hFFFE0001`.
  - Latency 16 in both builds.
- Backpressure: `a=16'h1234, b=16'h0100`, `out_ready=0` for 10 cycles after `out_valid`.
  - `p=32'h00123400` held stable, `in_ready=0` throughout.
  - Handshake returns to IDLE; a second op (`a=2, b=7` → `p=14`) is accepted the following edge.
- Zero and one operands: `a=16'hABCD, b=0` → `p=0`; `b=1` → `p=32'h0000ABCD`.
  - With the macro, latencies are 1 and 2 respectively.
- Reset mid-operation: assert `rst` asynchronously 5 cycles into RUN (`a=b=16'h00FF`).
  - Immediately `out_valid=0`, `in_ready=1`, `busy=0`, `p=0`.
  - After release, a new op `a=16'h8000, b=2` gives `p=32'h00010000`.
- Ignored stimulus: pulse `in_valid` with different `a`/`b` during RUN and change `a`/`b` mid-RUN.
  - The result still matches the operands sampled on the accept edge.
